// File: rtl/control_unit_pkg.sv
// Shared types and constants for the ultrasonic control unit.
package control_unit_pkg;

  localparam int unsigned DATA_W    = 25;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DAC_W     = 12;
  localparam int unsigned AMT_W     = 8;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
  localparam int unsigned DAC_SHIFT = 4;

  localparam logic [DAC_W-1:0] DAC_MAX = 12'hFFF;

  typedef enum logic {
    OFF    = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // DAC increment for a given step amount.
  function automatic logic [DAC_W-1:0] dac_step(input logic [AMT_W-1:0] amt);
    return DAC_W'(amt) << DAC_SHIFT;
  endfunction

endpackage

// File: rtl/control_unit_mem.sv
// Capture memory: 128 x 25 simple dual port, synchronous write, registered read.
// Ports:
//   clk, rst_n           clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr        read strobe and address
//   rd_data              registered read data, holds when rd_en=0
module control_unit_mem
  import control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Storage array is not reset; a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value between strobes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/control_unit.sv
// Ultrasonic submodule controller: on/off FSM, DAC power stepping, buffer
// send enable and sample capture into a memory readable from the AXI side.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ValidSignal                      qualifies every command/strobe
//   onSignal, offSignal              enable/disable (off wins)
//   sendEnable, rec_en               transmit / receive mode
//   increaseSignal, decreaseSignal   DAC step up/down on rising edge
//   AmountSignal                     step amount (scaled by 16)
//   buf_in                           sample to capture
//   rd_en, read_add                  AXI readback strobe/address
//   send_enB, sending, no_order      registered status outputs
//   outputDAC                        DAC power code
//   read_data                        AXI read data
module control_unit
  import control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidSignal,
  input  logic              onSignal,
  input  logic              offSignal,
  input  logic              sendEnable,
  input  logic              rec_en,
  input  logic              increaseSignal,
  input  logic              decreaseSignal,
  input  logic [AMT_W-1:0]  AmountSignal,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read_add,
  output logic              send_enB,
  output logic              sending,
  output logic              no_order,
  output logic [DAC_W-1:0]  outputDAC,
  output logic [DATA_W-1:0] read_data
);

  state_e            state_d, state_q;
  logic [DAC_W-1:0]  dac_d, dac_q;
  logic              inc_d, inc_q;
  logic              dec_d, dec_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic              send_en_d, send_en_q;
  logic              sending_d, sending_q;
  logic              no_order_d, no_order_q;

  logic              inc_edge_c;
  logic              dec_edge_c;
  logic              wr_en_c;
  logic [DAC_W-1:0]  step_c;
  logic [DAC_W:0]    sum_c;
  logic [DAC_W-1:0]  dac_add_c;
  logic [DAC_W-1:0]  dac_sub_c;

  // Saturating DAC arithmetic.
  always_comb begin
    step_c    = dac_step(AmountSignal);
    sum_c     = {1'b0, dac_q} + {1'b0, step_c};
    dac_add_c = sum_c[DAC_W] ? DAC_MAX : sum_c[DAC_W-1:0];
    dac_sub_c = (step_c > dac_q) ? '0 : (dac_q - step_c);
  end

  // Next-state, DAC, capture and status logic.
  always_comb begin
    state_d    = state_q;
    dac_d      = dac_q;
    inc_d      = increaseSignal;
    dec_d      = decreaseSignal;
    wr_ptr_d   = wr_ptr_q;
    inc_edge_c = increaseSignal & ~inc_q;
    dec_edge_c = decreaseSignal & ~dec_q;
    wr_en_c    = (state_q == ACTIVE) & rec_en & ValidSignal;

    // Coincident up and down edges cancel.
    if ((state_q == ACTIVE) && ValidSignal) begin
      if (inc_edge_c && !dec_edge_c) begin
        dac_d = dac_add_c;
      end else if (dec_edge_c && !inc_edge_c) begin
        dac_d = dac_sub_c;
      end
    end

    if (ValidSignal && offSignal) begin
      state_d = OFF;
      dac_d   = '0;
    end else if (ValidSignal && onSignal) begin
      state_d = ACTIVE;
    end

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    send_en_d  = (state_q == ACTIVE) & sendEnable;
    sending_d  = wr_en_c;
    no_order_d = ~(ValidSignal & (onSignal | offSignal | increaseSignal | decreaseSignal));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      dac_q      <= '0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      wr_ptr_q   <= '0;
      send_en_q  <= 1'b0;
      sending_q  <= 1'b0;
      no_order_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      dac_q      <= dac_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      wr_ptr_q   <= wr_ptr_d;
      send_en_q  <= send_en_d;
      sending_q  <= sending_d;
      no_order_q <= no_order_d;
    end
  end

  control_unit_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr_q),
    .wr_data (buf_in),
    .rd_en   (rd_en),
    .rd_addr (read_add),
    .rd_data (read_data)
  );

  assign send_enB  = send_en_q;
  assign sending   = sending_q;
  assign no_order  = no_order_q;
  assign outputDAC = dac_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized + directed bench for control_unit with a scoreboard queue.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        ValidSignal, onSignal, offSignal, sendEnable, rec_en;
  logic        increaseSignal, decreaseSignal, rd_en;
  logic [7:0]  AmountSignal;
  logic [24:0] buf_in;
  logic [6:0]  read_add;
  logic        send_enB, sending, no_order;
  logic [11:0] outputDAC;
  logic [24:0] read_data;

  control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ValidSignal    (ValidSignal),
    .onSignal       (onSignal),
    .offSignal      (offSignal),
    .sendEnable     (sendEnable),
    .rec_en         (rec_en),
    .increaseSignal (increaseSignal),
    .decreaseSignal (decreaseSignal),
    .AmountSignal   (AmountSignal),
    .buf_in         (buf_in),
    .rd_en          (rd_en),
    .read_add       (read_add),
    .send_enB       (send_enB),
    .sending        (sending),
    .no_order       (no_order),
    .outputDAC      (outputDAC),
    .read_data      (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       valid, on, off, snd, rec, inc, dec, rd;
    int       amt;
    int       data;
    int       addr;
  } stim_t;

  typedef struct {
    bit send_enB, sending, no_order;
    int dac;
    int rdata;
    bit rknown;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  bit m_active;
  int m_dac;
  bit m_pinc, m_pdec;
  int m_wp;
  int m_mem [128];
  bit m_known [128];
  int m_rdata;
  bit m_rknown;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_dac    = 0;
    m_pinc   = 1'b0;
    m_pdec   = 1'b0;
    m_wp     = 0;
    m_rdata  = 0;
    m_rknown = 1'b1;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit ie, de, we;
    e.no_order = !(s.valid && (s.on || s.off || s.inc || s.dec));
    e.send_enB = m_active && s.snd;
    we         = m_active && s.rec && s.valid;
    e.sending  = we;
    if (s.rd) begin
      m_rdata  = m_mem[s.addr];
      m_rknown = m_known[s.addr];
    end
    if (we) begin
      m_mem[m_wp]   = s.data;
      m_known[m_wp] = 1'b1;
      m_wp          = (m_wp + 1) % 128;
    end
    ie = s.inc && !m_pinc;
    de = s.dec && !m_pdec;
    if (m_active && s.valid) begin
      if (ie && !de) m_dac = (m_dac + s.amt * 16 > 4095) ? 4095 : m_dac + s.amt * 16;
      else if (de && !ie) m_dac = (m_dac - s.amt * 16 < 0) ? 0 : m_dac - s.amt * 16;
    end
    if (s.valid && s.off) begin
      m_active = 1'b0;
      m_dac    = 0;
    end else if (s.valid && s.on) begin
      m_active = 1'b1;
    end
    m_pinc   = s.inc;
    m_pdec   = s.dec;
    e.dac    = m_dac;
    e.rdata  = m_rdata;
    e.rknown = m_rknown;
  endtask

  task automatic apply(input stim_t s);
    ValidSignal    = s.valid;
    onSignal       = s.on;
    offSignal      = s.off;
    sendEnable     = s.snd;
    rec_en         = s.rec;
    increaseSignal = s.inc;
    decreaseSignal = s.dec;
    rd_en          = s.rd;
    AmountSignal   = 8'(s.amt);
    buf_in         = 25'(s.data);
    read_add       = 7'(s.addr);
  endtask

  // Drive one cycle and queue the expected response.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    apply(s);
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.valid = 0; s.on = 0; s.off = 0; s.snd = 0; s.rec = 0;
    s.inc = 0; s.dec = 0; s.rd = 0; s.amt = 0; s.data = 0; s.addr = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(99) < 75);
    s.on    = ($urandom_range(99) < 15);
    s.off   = ($urandom_range(99) < 4);
    s.snd   = ($urandom_range(99) < 50);
    s.rec   = ($urandom_range(99) < 50);
    s.inc   = ($urandom_range(99) < 40);
    s.dec   = ($urandom_range(99) < 40);
    s.rd    = ($urandom_range(99) < 50);
    s.amt   = int'($urandom_range(255));
    s.data  = int'($urandom_range(32'h01FF_FFFF));
    s.addr  = int'($urandom_range(127));
    return s;
  endfunction

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("send_enB", 32'(send_enB), 32'(e.send_enB));
        chk("sending", 32'(sending), 32'(e.sending));
        chk("no_order", 32'(no_order), 32'(e.no_order));
        chk("outputDAC", 32'(outputDAC), 32'(e.dac));
        if (e.rknown) chk("read_data", 32'(read_data), 32'(e.rdata));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_no_order"}, 32'(no_order), 32'd1);
    chk({tag, "_outputDAC"}, 32'(outputDAC), 32'd0);
    chk({tag, "_sending"}, 32'(sending), 32'd0);
    chk({tag, "_send_enB"}, 32'(send_enB), 32'd0);
    chk({tag, "_read_data"}, 32'(read_data), 32'd0);
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < 128; i++) begin
      m_mem[i]   = 0;
      m_known[i] = 1'b0;
    end
    model_reset();
    rst_n = 1'b0;
    apply(idle());
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(idle());
    // Capture attempt while OFF must not write or advance the pointer.
    s = idle(); s.valid = 1; s.rec = 1; s.data = 32'h0FF_FFFF;
    repeat (2) step(s);
    // Turn on, then single-step the DAC up and down with saturation at 0.
    s = idle(); s.valid = 1; s.on = 1; step(s);
    s = idle(); s.valid = 1; s.inc = 1; s.amt = 1; step(s);
    step(idle());
    s = idle(); s.valid = 1; s.dec = 1; s.amt = 1; step(s);
    step(idle());
    step(s);
    step(idle());
    // Saturate high with 17 max-size edges, then switch off.
    for (int i = 0; i < 17; i++) begin
      s = idle(); s.valid = 1; s.inc = 1; s.amt = 255; step(s);
      step(idle());
    end
    s = idle(); s.valid = 1; s.off = 1; step(s);
    // Fill past the end of memory to exercise pointer wrap.
    s = idle(); s.valid = 1; s.on = 1; step(s);
    for (int i = 0; i < 130; i++) begin
      s = idle(); s.valid = 1; s.rec = 1; s.data = i; step(s);
    end
    for (int a = 0; a < 3; a++) begin
      s = idle(); s.rd = 1; s.addr = a; step(s);
    end
    step(idle());
    // Send enable follows ACTIVE; on+off together lands in OFF.
    s = idle(); s.snd = 1; step(s);
    s = idle(); s.valid = 1; s.on = 1; s.off = 1; s.snd = 1; step(s);
    s = idle(); s.snd = 1; step(s);
    step(idle());

    for (int i = 0; i < 2000; i++) step(rand_stim());
    step(idle());
    drain();

    // Asynchronous reset mid-cycle with a write in flight.
    s = idle(); s.valid = 1; s.on = 1; step(s);
    drain();
    @(negedge clk);
    s = idle(); s.valid = 1; s.rec = 1; s.data = 32'h155_5555; s.inc = 1; s.amt = 200;
    apply(s);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    @(negedge clk);
    apply(idle());
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) step(rand_stim());
    s = idle(); s.rd = 1; s.addr = 0; step(s);
    step(idle());
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
